result_checker: RTL and testbench
=================================

RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 SHALL have parameter ADDR_W, 12, width of result/golden memory address (covers 63x63 = 3969 pixels).
REQ-002 SHALL have parameter DATA_W, 8, pixel width.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  one-cycle request to check a finished result frame (driven from the resize engine's DONE).
REQ-006 SHALL have port TW  input  6  target width in pixels; sampled only when START is accepted.
REQ-007 SHALL have port TH  input  6  target height in pixels; sampled only when START is accepted.
REQ-008 SHALL have port RS_RE  output  1  result SRAM read enable.
REQ-009 SHALL have port RS_A  output  ADDR_W  result SRAM read address, raster order j*TW+i.
REQ-010 SHALL have port RS_Q  input  DATA_W  result SRAM read data, valid exactly one cycle after RS_RE/RS_A.
REQ-011 SHALL have port GA  output  ADDR_W  shared address to both golden ROMs; always equal to RS_A.
REQ-012 SHALL have port G1_Q  input  DATA_W  golden image 1 data, same one-cycle latency as RS_Q.
REQ-013 SHALL have port G2_Q  input  DATA_W  golden image 2 (alternate rounding) data, same latency.
REQ-014 SHALL have port BUSY  output  1  high from START acceptance until CHK_DONE inclusive.
REQ-015 SHALL have port CHK_DONE  output  1  one-cycle pulse: result registers final.
REQ-016 SHALL have port ERR_CNT  output  ADDR_W  number of mismatching pixels.
REQ-017 SHALL have port FIRST_ERR_IDX  output  ADDR_W  raster index of first mismatch.
REQ-018 SHALL have port FIRST_ERR_VLD  output  1  FIRST_ERR_IDX holds a valid index.
REQ-019 SHALL have port PASS  output  1  high when the last check found ERR_CNT == 0; valid from CHK_DONE until next START.

Function
REQ-020 SHALL implement FSM IDLE -> READ -> DRAIN -> FIN -> IDLE.
REQ-021 SHALL accept START only in IDLE; START in any other state ignored, no side effect.
REQ-022 On accepted START (edge k): latch TW, TH; compute N = TW*TH (12-bit, unsigned, exact); clear ERR_CNT, FIRST_ERR_IDX, FIRST_ERR_VLD, PASS; set BUSY.
REQ-023 If N == 0: go directly to FIN; no RS_RE pulses; CHK_DONE at edge k+1 with ERR_CNT=0, PASS=1.
REQ-024 READ: present addresses 0..N-1 on consecutive cycles after edges k..k+N-1, RS_RE=1 each cycle, no gaps; RS_RE=0 and RS_A held at last value otherwise.
REQ-025 DRAIN: one cycle to capture data for address N-1; no read issued.
REQ-026 Pixel p SHALL be compared one cycle after its address; match iff RS_Q == G1_Q or RS_Q == G2_Q.
REQ-027 On mismatch: ERR_CNT += 1, saturating at 2^ADDR_W-1; if FIRST_ERR_VLD==0, load FIRST_ERR_IDX=p and set FIRST_ERR_VLD.
REQ-028 FIN: CHK_DONE=1 for exactly one cycle, at edge k+N+1 (N>0); PASS = (ERR_CNT==0); BUSY drops the following cycle.
REQ-029 ERR_CNT, FIRST_ERR_*, PASS SHALL hold until the next accepted START or reset.
REQ-030 A START coincident with CHK_DONE SHALL be ignored; earliest acceptance is the cycle after FIN.

Reset
REQ-031 RST_N low SHALL immediately force: state IDLE, RS_RE=0, RS_A=0, GA=0, BUSY=0, CHK_DONE=0, ERR_CNT=0, FIRST_ERR_IDX=0, FIRST_ERR_VLD=0, PASS=0.
REQ-032 Reset mid-check SHALL abort with no CHK_DONE; first START after release starts a fresh check.

Verification
REQ-033 TW=4, TH=4, all RS_Q==G1_Q -> 16 RS_RE cycles, addresses 0..15, CHK_DONE at k+17, ERR_CNT=0, PASS=1.
REQ-034 TW=4, TH=4, RS_Q corrupt at indices 5 and 9 (differs from both goldens) -> ERR_CNT=2, FIRST_ERR_IDX=5, FIRST_ERR_VLD=1, PASS=0.
REQ-035 TW=3, TH=2, RS_Q==G2_Q!=G1_Q at every index -> ERR_CNT=0, PASS=1.
REQ-036 TW=0, TH=7 -> no RS_RE, CHK_DONE at k+1, PASS=1.
REQ-037 TW=63, TH=63 all mismatch -> ERR_CNT=3969, CHK_DONE at k+3970; START pulsed at k+100 ignored.
REQ-038 RST_N low at k+5 of a 16-pixel check -> outputs at reset values immediately, no CHK_DONE; new START yields correct full result.

Source files
------------

// File: rtl/result_checker.sv
// Result checker: streams a finished result frame out of the result SRAM and
// compares every pixel against two golden images, reporting the error count and the first failing index.
module result_checker #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [5:0]        TW,
    input  logic [5:0]        TH,
    output logic              RS_RE,
    output logic [ADDR_W-1:0] RS_A,
    input  logic [DATA_W-1:0] RS_Q,
    output logic [ADDR_W-1:0] GA,
    input  logic [DATA_W-1:0] G1_Q,
    input  logic [DATA_W-1:0] G2_Q,
    output logic              BUSY,
    output logic              CHK_DONE,
    output logic [ADDR_W-1:0] ERR_CNT,
    output logic [ADDR_W-1:0] FIRST_ERR_IDX,
    output logic              FIRST_ERR_VLD,
    output logic              PASS
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] n_start;
    logic [ADDR_W-1:0] n_q;
    logic              accept;
    logic              last_addr;
    logic              cmp_vld;
    logic [ADDR_W-1:0] cmp_idx;
    logic              mismatch;
    logic [ADDR_W-1:0] err_nxt;

    assign n_start   = ADDR_W'(TW) * ADDR_W'(TH);
    assign accept    = (state == IDLE) && START;
    assign last_addr = (RS_A == n_q - ADDR_W'(1));
    assign mismatch  = cmp_vld && (RS_Q != G1_Q) && (RS_Q != G2_Q);
    assign err_nxt   = (mismatch && (ERR_CNT != '1)) ? ERR_CNT + ADDR_W'(1) : ERR_CNT;

    assign GA       = RS_A;
    assign BUSY     = (state != IDLE);
    assign CHK_DONE = (state == FIN);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An empty frame still spends one cycle in DRAIN so CHK_DONE lands one edge after acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = (n_start == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (last_addr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN:   state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            n_q   <= '0;
            RS_RE <= 1'b0;
            RS_A  <= '0;
        end else if (accept) begin
            n_q <= n_start;
            if (n_start != '0) begin
                RS_RE <= 1'b1;
                RS_A  <= '0;
            end
        end else if (state == READ) begin
            if (last_addr) begin
                RS_RE <= 1'b0;
            end else begin
                RS_A <= RS_A + ADDR_W'(1);
            end
        end
    end

    // Data returns one cycle after its address, so the compare stage trails the read stage by one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cmp_vld <= 1'b0;
            cmp_idx <= '0;
        end else begin
            cmp_vld <= RS_RE;
            cmp_idx <= RS_A;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR_CNT       <= '0;
            FIRST_ERR_IDX <= '0;
            FIRST_ERR_VLD <= 1'b0;
            PASS          <= 1'b0;
        end else if (accept) begin
            ERR_CNT       <= '0;
            FIRST_ERR_IDX <= '0;
            FIRST_ERR_VLD <= 1'b0;
            PASS          <= 1'b0;
        end else begin
            ERR_CNT <= err_nxt;
            if (mismatch && !FIRST_ERR_VLD) begin
                FIRST_ERR_IDX <= cmp_idx;
                FIRST_ERR_VLD <= 1'b1;
            end
            // The last pixel is compared on the same edge that enters FIN.
            if (state == DRAIN) begin
                PASS <= (err_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Self-checking bench for result_checker: SRAM/ROM models, an address
// scoreboard, and one task per scenario with inline comparisons.
module tb_result_checker;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [5:0]  TW;
    logic [5:0]  TH;
    logic        RS_RE;
    logic [11:0] RS_A;
    logic [7:0]  RS_Q;
    logic [11:0] GA;
    logic [7:0]  G1_Q;
    logic [7:0]  G2_Q;
    logic        BUSY;
    logic        CHK_DONE;
    logic [11:0] ERR_CNT;
    logic [11:0] FIRST_ERR_IDX;
    logic        FIRST_ERR_VLD;
    logic        PASS;

    logic [7:0] res_mem [0:4095];
    logic [7:0] g1_mem  [0:4095];
    logic [7:0] g2_mem  [0:4095];

    int checks = 0;
    int errors = 0;
    int exp_addr[$];
    int addr_err;

    result_checker #(.ADDR_W(12), .DATA_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .TW(TW), .TH(TH),
        .RS_RE(RS_RE), .RS_A(RS_A), .RS_Q(RS_Q), .GA(GA),
        .G1_Q(G1_Q), .G2_Q(G2_Q), .BUSY(BUSY), .CHK_DONE(CHK_DONE),
        .ERR_CNT(ERR_CNT), .FIRST_ERR_IDX(FIRST_ERR_IDX),
        .FIRST_ERR_VLD(FIRST_ERR_VLD), .PASS(PASS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle-latency memory models.
    always @(posedge CLK) begin
        if (RS_RE) RS_Q <= res_mem[RS_A];
        G1_Q <= g1_mem[GA];
        G2_Q <= g2_mem[GA];
    end

    task automatic fill_clean();
        for (int i = 0; i < 4096; i++) begin
            g1_mem[i]  = 8'($urandom);
            g2_mem[i]  = g1_mem[i] ^ 8'h0F;
            res_mem[i] = g1_mem[i];
        end
    endtask

    function automatic void model(input int n, output int err, output int first, output bit vld);
        err = 0; first = 0; vld = 0;
        for (int p = 0; p < n; p++) begin
            if (res_mem[p] !== g1_mem[p] && res_mem[p] !== g2_mem[p]) begin
                if (!vld) begin first = p; vld = 1; end
                err++;
            end
        end
    endfunction

    // Drives one START and observes the frame; RS_A is popped against the scoreboard.
    task automatic run_frame(input int tw, input int th, input int stray_at,
                             output int done_lat, output int re_cnt, output int done_cnt,
                             output logic busy_after);
        int n;
        int e;
        n = tw * th;
        done_lat = -1; re_cnt = 0; done_cnt = 0; busy_after = 1'b1;
        addr_err = 0;
        for (int p = 0; p < n; p++) exp_addr.push_back(p);
        @(negedge CLK);
        TW = 6'(tw); TH = 6'(th); START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int t = 0; t < n + 40; t++) begin
            if (RS_RE) begin
                re_cnt++;
                if (exp_addr.size() == 0) addr_err++;
                else begin
                    e = exp_addr.pop_front();
                    if (int'(RS_A) != e) addr_err++;
                end
            end
            if (GA !== RS_A) addr_err++;
            if (CHK_DONE) begin
                done_cnt++;
                if (done_lat < 0) done_lat = t;
            end
            if (done_lat >= 0 && t >= done_lat + 2) begin
                busy_after = BUSY;
                break;
            end
            START = (t + 1 == stray_at);
            @(negedge CLK);
        end
        START = 1'b0;
        addr_err += exp_addr.size();
        exp_addr.delete();
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START = 1'b0; TW = '0; TH = '0;
        #3;
        checks++; if ({RS_RE, BUSY, CHK_DONE, FIRST_ERR_VLD, PASS} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {RS_RE, BUSY, CHK_DONE, FIRST_ERR_VLD, PASS}); end
        checks++; if (RS_A !== 12'd0 || GA !== 12'd0) begin errors++; $display("FAIL reset_addr: got %0d/%0d expected 0/0", RS_A, GA); end
        checks++; if (ERR_CNT !== 12'd0 || FIRST_ERR_IDX !== 12'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", ERR_CNT, FIRST_ERR_IDX); end
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || RS_RE !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b re=%b expected 0 0", BUSY, RS_RE); end
    endtask

    task automatic test_clean_4x4();
        int lat, re, dn, err, first; bit vld; logic busy_after;
        fill_clean();
        model(16, err, first, vld);
        run_frame(4, 4, -1, lat, re, dn, busy_after);
        checks++; if (addr_err != 0) begin errors++; $display("FAIL clean_addr: got %0d address errors expected 0", addr_err); end
        checks++; if (re != 16) begin errors++; $display("FAIL clean_re_cnt: got %0d expected 16", re); end
        checks++; if (lat != 17) begin errors++; $display("FAIL clean_done_lat: got %0d expected 17", lat); end
        checks++; if (dn != 1) begin errors++; $display("FAIL clean_done_pulse: got %0d expected 1", dn); end
        checks++; if (int'(ERR_CNT) != err || PASS !== 1'b1 || FIRST_ERR_VLD !== vld) begin errors++; $display("FAIL clean_result: got err=%0d pass=%b vld=%b expected %0d 1 %0d", ERR_CNT, PASS, FIRST_ERR_VLD, err, vld); end
        checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL clean_busy_drop: got %b expected 0", busy_after); end
    endtask

    task automatic test_errors_4x4();
        int lat, re, dn, err, first; bit vld; logic busy_after;
        fill_clean();
        res_mem[5] = g1_mem[5] ^ 8'hF0;
        res_mem[9] = g1_mem[9] ^ 8'hF0;
        model(16, err, first, vld);
        run_frame(4, 4, -1, lat, re, dn, busy_after);
        checks++; if (int'(ERR_CNT) != err || err != 2) begin errors++; $display("FAIL err_count: got %0d expected 2", ERR_CNT); end
        checks++; if (int'(FIRST_ERR_IDX) != first || FIRST_ERR_VLD !== 1'b1) begin errors++; $display("FAIL err_first: got idx=%0d vld=%b expected 5 1", FIRST_ERR_IDX, FIRST_ERR_VLD); end
        checks++; if (PASS !== 1'b0) begin errors++; $display("FAIL err_pass: got %b expected 0", PASS); end
        repeat (5) @(negedge CLK);
        checks++; if (ERR_CNT !== 12'd2 || FIRST_ERR_IDX !== 12'd5) begin errors++; $display("FAIL err_hold: got %0d/%0d expected 2/5", ERR_CNT, FIRST_ERR_IDX); end
    endtask

    task automatic test_alt_golden();
        int lat, re, dn; logic busy_after;
        fill_clean();
        for (int i = 0; i < 6; i++) res_mem[i] = g2_mem[i];
        run_frame(3, 2, -1, lat, re, dn, busy_after);
        checks++; if (addr_err != 0 || re != 6) begin errors++; $display("FAIL alt_reads: got re=%0d addr_err=%0d expected 6 0", re, addr_err); end
        checks++; if (lat != 7) begin errors++; $display("FAIL alt_done_lat: got %0d expected 7", lat); end
        checks++; if (ERR_CNT !== 12'd0 || PASS !== 1'b1) begin errors++; $display("FAIL alt_result: got err=%0d pass=%b expected 0 1", ERR_CNT, PASS); end
    endtask

    task automatic test_zero_size();
        int lat, re, dn; logic busy_after;
        run_frame(0, 7, -1, lat, re, dn, busy_after);
        checks++; if (re != 0) begin errors++; $display("FAIL zero_re: got %0d expected 0", re); end
        checks++; if (lat != 1 || dn != 1) begin errors++; $display("FAIL zero_done: got lat=%0d pulses=%0d expected 1 1", lat, dn); end
        checks++; if (ERR_CNT !== 12'd0 || PASS !== 1'b1) begin errors++; $display("FAIL zero_result: got err=%0d pass=%b expected 0 1", ERR_CNT, PASS); end
    endtask

    task automatic test_back_to_back();
        int lat, re, dn, err, first; bit vld; logic busy_after;
        fill_clean();
        res_mem[2] = g1_mem[2] ^ 8'hF0;
        model(4, err, first, vld);
        run_frame(2, 2, 6, lat, re, dn, busy_after);
        checks++; if (re != 4 || busy_after !== 1'b0) begin errors++; $display("FAIL b2b_ignored_start: got re=%0d busy=%b expected 4 0", re, busy_after); end
        checks++; if (int'(ERR_CNT) != err || int'(FIRST_ERR_IDX) != first) begin errors++; $display("FAIL b2b_result: got %0d/%0d expected %0d/%0d", ERR_CNT, FIRST_ERR_IDX, err, first); end
        run_frame(2, 2, -1, lat, re, dn, busy_after);
        checks++; if (re != 4 || lat != 5 || addr_err != 0) begin errors++; $display("FAIL b2b_next: got re=%0d lat=%0d expected 4 5", re, lat); end
    endtask

    task automatic test_full_frame();
        int lat, re, dn, err, first; bit vld; logic busy_after;
        for (int i = 0; i < 4096; i++) begin
            g1_mem[i]  = 8'($urandom);
            g2_mem[i]  = g1_mem[i] ^ 8'h5A;
            res_mem[i] = g1_mem[i] ^ 8'hA5;
        end
        model(3969, err, first, vld);
        run_frame(63, 63, 100, lat, re, dn, busy_after);
        checks++; if (re != 3969 || addr_err != 0) begin errors++; $display("FAIL full_reads: got re=%0d addr_err=%0d expected 3969 0", re, addr_err); end
        checks++; if (lat != 3970) begin errors++; $display("FAIL full_done_lat: got %0d expected 3970", lat); end
        checks++; if (int'(ERR_CNT) != err || err != 3969 || PASS !== 1'b0) begin errors++; $display("FAIL full_result: got err=%0d pass=%b expected 3969 0", ERR_CNT, PASS); end
        checks++; if (FIRST_ERR_IDX !== 12'd0 || FIRST_ERR_VLD !== 1'b1) begin errors++; $display("FAIL full_first: got %0d/%b expected 0/1", FIRST_ERR_IDX, FIRST_ERR_VLD); end
    endtask

    task automatic test_reset_mid();
        int lat, re, dn, err, first, stray; bit vld; logic busy_after;
        fill_clean();
        res_mem[3] = g1_mem[3] ^ 8'hF0;
        res_mem[1] = g1_mem[1] ^ 8'hF0;
        @(negedge CLK);
        TW = 6'd4; TH = 6'd4; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        checks++; if ({RS_RE, BUSY, CHK_DONE} !== 3'b000 || RS_A !== 12'd0 || GA !== 12'd0) begin errors++; $display("FAIL midreset_outputs: got re=%b busy=%b done=%b a=%0d ga=%0d expected all 0", RS_RE, BUSY, CHK_DONE, RS_A, GA); end
        checks++; if (ERR_CNT !== 12'd0 || FIRST_ERR_VLD !== 1'b0 || PASS !== 1'b0) begin errors++; $display("FAIL midreset_results: got %0d/%b/%b expected 0/0/0", ERR_CNT, FIRST_ERR_VLD, PASS); end
        stray = 0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        for (int t = 0; t < 25; t++) begin
            @(negedge CLK);
            if (CHK_DONE || RS_RE) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", stray); end
        model(16, err, first, vld);
        run_frame(4, 4, -1, lat, re, dn, busy_after);
        checks++; if (int'(ERR_CNT) != err || int'(FIRST_ERR_IDX) != first || lat != 17 || re != 16) begin errors++; $display("FAIL midreset_fresh: got err=%0d first=%0d lat=%0d re=%0d expected %0d %0d 17 16", ERR_CNT, FIRST_ERR_IDX, lat, re, err, first); end
    endtask

    initial begin
        test_reset();
        test_clean_4x4();
        test_errors_4x4();
        test_clean_4x4();
        test_alt_golden();
        test_zero_size();
        test_back_to_back();
        test_full_frame();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
